// File: rtl/pkg_buffer_if.sv
// Detector-side capture inputs and the replay stream of the packet buffer.
interface pkg_buffer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [2*WIDTH-1:0] data_i;
  logic               start_i;
  logic               valid_i;
  logic [2*WIDTH-1:0] pkt_data_o;
  logic               pkt_valid_o;
  logic               pkt_ready_i;
  logic               pkt_last_o;
  logic [LW-1:0]      pkt_len_o;

  modport slave (
    input  data_i, start_i, valid_i, pkt_ready_i,
    output pkt_data_o, pkt_valid_o, pkt_last_o, pkt_len_o
  );

  modport master (
    output data_i, start_i, valid_i, pkt_ready_i,
    input  pkt_data_o, pkt_valid_o, pkt_last_o, pkt_len_o
  );
endinterface

// File: rtl/pkg_buffer.sv
// Single-packet capture buffer: stores words while start_i is high, replays them
// on a ready/valid stream after the closing valid_i pulse, and counts drops.
module pkg_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  pkg_buffer_if.slave       bus,
  output logic              busy_o,
  output logic [7:0]        drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = 2 * WIDTH;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [DW-1:0] STOP = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DISCARD, S_DRAIN} state_t;

  state_t        r_state;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_cnt;
  logic [AW-1:0] r_wptr, r_rptr;
  logic          r_start_d;
  logic [DW-1:0] r_data;
  logic          r_valid, r_last, r_busy;
  logic [AW:0]   r_len;
  logic [7:0]    r_drop;

  logic          w_stop, w_rise, w_xfer, w_we, w_drop_inc;
  logic [AW-1:0] w_waddr, w_rnext;

  assign w_stop  = (bus.data_i == STOP);
  assign w_rise  = bus.start_i & ~r_start_d;
  assign w_xfer  = r_valid & bus.pkt_ready_i;
  assign w_rnext = r_rptr + 1'b1;
  assign w_waddr = (r_state == S_IDLE) ? '0 : r_wptr;

  assign w_we = ((r_state == S_IDLE) && w_rise && !w_stop) ||
                ((r_state == S_CAPTURE) && !bus.valid_i && bus.start_i &&
                 !w_stop && (r_cnt != FULL));

  // Overflow of the current capture, or a packet that starts while replaying.
  assign w_drop_inc = ((r_state == S_CAPTURE) && !bus.valid_i && bus.start_i &&
                       !w_stop && (r_cnt == FULL)) ||
                      ((r_state == S_DRAIN) && w_rise);

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= bus.data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_start_d <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_len     <= '0;
      r_drop    <= '0;
    end else begin
      r_start_d <= bus.start_i;
      if (w_drop_inc && (r_drop != 8'hff)) r_drop <= r_drop + 8'd1;
      case (r_state)
        S_IDLE: begin
          // A leading stop marker opens the packet without storing anything.
          if (w_rise) begin
            r_state <= S_CAPTURE;
            r_busy  <= 1'b1;
            r_cnt   <= w_stop ? '0 : (AW+1)'(1);
            r_wptr  <= w_stop ? '0 : AW'(1);
          end
        end
        S_CAPTURE: begin
          if (bus.valid_i) begin
            if (r_cnt == '0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DRAIN;
              r_len   <= r_cnt;
              r_rptr  <= '0;
              r_data  <= r_mem['0];
              r_valid <= 1'b1;
              r_last  <= (r_cnt == (AW+1)'(1));
            end
          end else if (bus.start_i && !w_stop) begin
            if (r_cnt != FULL) begin
              r_cnt  <= r_cnt + 1'b1;
              r_wptr <= r_wptr + 1'b1;
            end else begin
              r_state <= S_DISCARD;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DISCARD: begin
          if (bus.valid_i) r_state <= S_IDLE;
        end
        S_DRAIN: begin
          if (w_xfer) begin
            if (r_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_rptr <= w_rnext;
              r_data <= r_mem[w_rnext];
              r_last <= (({1'b0, w_rnext} + 1'b1) == r_len);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pkt_data_o  = r_data;
  assign bus.pkt_valid_o = r_valid;
  assign bus.pkt_last_o  = r_last;
  assign bus.pkt_len_o   = r_len;
  assign busy_o          = r_busy;
  assign drop_cnt_o      = r_drop;
endmodule

// File: doc/pkg_buffer.md
# pkg_buffer

Packet capture buffer directly downstream of the packet detector in the FM demodulator chain. It stores the demodulated 2*WIDTH-bit words that arrive while the detector's `start` flag is high. When the detector's one-cycle `valid` pulse closes the packet, the block replays the stored packet on a ready/valid stream with length and last-word markers. It holds one packet at a time and counts packets it has to drop.

## Interface
- `WIDTH`, 16: half data width; words are 2*WIDTH bits, matching the demodulator and detector.
- `DEPTH`, 64: payload capacity in words; power of two, at least 4.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `data_i` in 2*WIDTH: signed word, aligned to the word the detector compares in the same cycle.
- `start_i` in 1: detector `start_o`; high while inside a packet.
- `valid_i` in 1: detector `valid_o`; one-cycle pulse that ends the packet.
- `pkt_data_o` out 2*WIDTH: payload word.
- `pkt_valid_o` out 1: `pkt_data_o` is valid.
- `pkt_ready_i` in 1: downstream accepts the word.
- `pkt_last_o` out 1: current word is the last of the packet.
- `pkt_len_o` out $clog2(DEPTH)+1: word count of the packet; stable for the whole drain.
- `busy_o` out 1: high in CAPTURE or DRAIN.
- `drop_cnt_o` out 8: number of dropped packets; saturates at 255.

## Operation
- Storage is a DEPTH x 2*WIDTH memory with write pointer `wptr`, read pointer `rptr`, and word count `cnt` (0..DEPTH).
- FSM states are IDLE, CAPTURE, DISCARD, and DRAIN.
- **IDLE**
  - `start_i`=1: write `data_i` at address 0, set `cnt`=1, go to CAPTURE.
  - `valid_i` alone is ignored.
- **CAPTURE**
  - `valid_i`=1 has priority over `start_i`. If `cnt`=0, go to IDLE with no output. Otherwise latch `pkt_len_o`=`cnt`, clear `rptr`, and go to DRAIN.
  - Otherwise, if `start_i`=1:
    - `data_i`=32'h80000000 (stop marker): the word is not stored.
    - `cnt`<DEPTH: write the word and increment `cnt`.
    - `cnt`=DEPTH (overflow): increment `drop_cnt_o` and go to DISCARD.
  - `start_i`=0 with no `valid_i`: stay in CAPTURE and write nothing.
- **DISCARD**
  - Write nothing.
  - `valid_i`=1: go to IDLE.
- **DRAIN**
  - Output is an AXI-style stream. A word transfers on a cycle with `pkt_valid_o`=1 and `pkt_ready_i`=1.
  - `pkt_data_o` = mem[`rptr`].
  - `pkt_last_o` = (`rptr` = `pkt_len_o`-1).
  - `rptr` increments on each transfer.
  - The transfer of the last word returns the FSM to IDLE.
  - A new `start_i` rising edge while in DRAIN counts as a drop: increment `drop_cnt_o` once per packet, i.e. on the 0->1 edge of `start_i`. That packet is never captured, even if DRAIN ends while it is still in progress. Capture needs a fresh `start_i` rising edge seen in IDLE.
- Width rules:
  - `cnt` and `pkt_len_o` are $clog2(DEPTH)+1 bits, so DEPTH itself is representable.
  - `wptr` and `rptr` are $clog2(DEPTH) bits and never wrap inside a packet.
- Reset (`rst`=0, asynchronous):
  - FSM goes to IDLE; `cnt`, `wptr`, and `rptr` go to 0.
  - `pkt_valid_o`=0, `pkt_last_o`=0, `pkt_len_o`=0, `busy_o`=0, `drop_cnt_o`=0.
  - Memory contents are not reset.
  - Reset during CAPTURE or DRAIN discards the packet; no partial output follows.

## Timing
- Write latency: the word is written at the same edge that samples `start_i`=1.
- `pkt_valid_o` rises 1 cycle after the edge that samples `valid_i`; that is, it is registered and high in the first DRAIN cycle.
- `pkt_valid_o`, `pkt_data_o`, and `pkt_last_o` are held constant while `pkt_ready_i`=0. `pkt_valid_o` never drops before the last transfer.
- With `pkt_ready_i` held at 1, N words drain in N consecutive cycles. `pkt_valid_o` is 0 in the cycle after the last transfer.
- Minimum gap from last transfer to the next capture is 1 cycle: the IDLE cycle.
- `busy_o` and `pkt_len_o` are registered outputs.
- `drop_cnt_o` updates 1 cycle after the triggering edge and holds at 255.

## Test plan
- **Basic packet:** `start_i` high for 5 cycles with data 1..5, then `valid_i` pulse, `pkt_ready_i`=1 -> 1 cycle later `pkt_len_o`=5, then 1,2,3,4,5 on consecutive cycles, `pkt_last_o` only on 5, `drop_cnt_o`=0.
- **Backpressure:** same packet with `pkt_ready_i` toggling 1,0,0,1,... -> each word held stable while not ready; order 1..5 is preserved and no duplicates appear.
- **Overflow and zero-length:**
  - DEPTH=64 with 65 words -> nothing output, `drop_cnt_o`=1, IDLE after `valid_i`.
  - `start_i` pulse followed by `valid_i` with only a stop-marker word -> no output.
- **Busy drop:** second packet arrives during a drain held with `pkt_ready_i`=0 -> `drop_cnt_o` increments by 1, first packet drains intact, and the second packet is never emitted.
- **Reset mid-operation:** assert `rst`=0 asynchronously in mid-capture and again in mid-drain -> all outputs go to 0 immediately; after release, a clean 3-word packet is captured and replayed correctly.
- **Saturation and priority:**
  - 300 overflow packets -> `drop_cnt_o` stays at 255.
  - `start_i` and `valid_i` high in the same CAPTURE cycle -> the word is not stored and DRAIN begins.
